// File: rtl/lpif_tx_packer.sv
// Packs link-layer byte chunks back-to-back into 64-byte LPIF words and hands
// each word to the PHY over an lp_irdy/pl_trdy handshake.
module lpif_tx_packer #(
    parameter int IN_BYTES      = 8,
    parameter int FLUSH_TIMEOUT = 16
) (
    input  logic                       pclk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [8*IN_BYTES-1:0]      in_data,
    input  logic [$clog2(IN_BYTES):0]  in_bytes,
    input  logic                       in_sop,
    input  logic                       in_eop,
    input  logic                       in_is_dlp,
    input  logic                       flush,
    output logic [511:0]               lp_data,
    output logic [63:0]                lp_valid,
    output logic [63:0]                lp_tlpstart,
    output logic [63:0]                lp_tlpend,
    output logic [63:0]                lp_dlpstart,
    output logic [63:0]                lp_dlpend,
    output logic                       lp_irdy,
    input  logic                       pl_trdy,
    output logic                       proto_err
);

    localparam logic [6:0] FILL_LIM = 7'(64 - IN_BYTES);
    localparam logic [6:0] IN_MAX   = 7'(IN_BYTES);
    localparam logic [7:0] IDLE_MAX = 8'(FLUSH_TIMEOUT);

    // accumulator
    logic [511:0] acc_data_q, acc_data_d;
    logic [63:0]  acc_valid_q, acc_valid_d;
    logic [63:0]  acc_ts_q, acc_ts_d, acc_te_q, acc_te_d;
    logic [63:0]  acc_ds_q, acc_ds_d, acc_de_q, acc_de_d;
    logic [6:0]   fill_q, fill_d;
    logic [7:0]   idle_q, idle_d;
    logic         in_pkt_q, in_pkt_d;
    logic         pkt_dlp_q, pkt_dlp_d;

    // output register
    logic [511:0] out_data_q, out_data_d;
    logic [63:0]  out_valid_q, out_valid_d;
    logic [63:0]  out_ts_q, out_ts_d, out_te_q, out_te_d;
    logic [63:0]  out_ds_q, out_ds_d, out_de_q, out_de_d;
    logic         irdy_q, irdy_d;
    logic         perr_q, perr_d;

    logic         can_xfer, seal, xfer, accept;
    logic         bad_len, no_sop, keep, proto_viol, end_dlp;
    logic [6:0]   n_bytes, base;
    logic [5:0]   last;
    logic [63:0]  start_bit, end_bit;
    logic [63:0]  wr_en;
    logic [511:0] wr_data;

    assign n_bytes  = 7'(in_bytes);
    assign can_xfer = (fill_q != 7'd0) && (!irdy_q || pl_trdy);
    assign seal     = (fill_q > FILL_LIM) || flush || (idle_q == IDLE_MAX);
    assign xfer     = seal && can_xfer;
    assign in_ready = (fill_q <= FILL_LIM) || can_xfer;
    assign accept   = in_valid && in_ready;

    assign bad_len    = (n_bytes == 7'd0) || (n_bytes > IN_MAX);
    assign no_sop     = !in_sop && !in_pkt_q;
    assign keep       = accept && !bad_len && !no_sop;
    assign proto_viol = accept && (bad_len || no_sop || (in_sop && in_pkt_q) ||
                                   ((n_bytes < IN_MAX) && !in_eop));

    // A chunk lands at byte 0 when the word it would join leaves on this edge.
    assign base      = xfer ? 7'd0 : fill_q;
    assign last      = base[5:0] + n_bytes[5:0] - 6'd1;
    assign start_bit = 64'd1 << base[5:0];
    assign end_bit   = 64'd1 << last;
    assign end_dlp   = in_sop ? in_is_dlp : pkt_dlp_q;

    for (genvar gi = 0; gi < 64; gi++) begin : g_byte
        logic [5:0] off;
        assign off       = 6'(gi) - base[5:0];
        assign wr_en[gi] = keep && (7'(gi) >= base) && (7'(gi) < base + n_bytes);
        assign wr_data[gi*8 +: 8] = wr_en[gi] ? 8'(in_data >> {off, 3'b000}) : 8'h00;
    end

    always_comb begin
        acc_data_d  = xfer ? '0 : acc_data_q;
        acc_valid_d = xfer ? '0 : acc_valid_q;
        acc_ts_d    = xfer ? '0 : acc_ts_q;
        acc_te_d    = xfer ? '0 : acc_te_q;
        acc_ds_d    = xfer ? '0 : acc_ds_q;
        acc_de_d    = xfer ? '0 : acc_de_q;
        fill_d      = xfer ? 7'd0 : fill_q;
        idle_d      = idle_q;
        in_pkt_d    = in_pkt_q;
        pkt_dlp_d   = pkt_dlp_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_ts_d    = out_ts_q;
        out_te_d    = out_te_q;
        out_ds_d    = out_ds_q;
        out_de_d    = out_de_q;
        irdy_d      = irdy_q;
        perr_d      = proto_viol;

        if (xfer) begin
            out_data_d  = acc_data_q;
            out_valid_d = acc_valid_q;
            out_ts_d    = acc_ts_q;
            out_te_d    = acc_te_q;
            out_ds_d    = acc_ds_q;
            out_de_d    = acc_de_q;
            irdy_d      = 1'b1;
        end else if (irdy_q && pl_trdy) begin
            irdy_d = 1'b0;
        end

        if (keep) begin
            acc_data_d  = acc_data_d | wr_data;
            acc_valid_d = acc_valid_d | wr_en;
            if (in_sop) begin
                pkt_dlp_d = in_is_dlp;
                if (in_is_dlp) acc_ds_d = acc_ds_d | start_bit;
                else           acc_ts_d = acc_ts_d | start_bit;
            end
            if (in_eop) begin
                if (end_dlp) acc_de_d = acc_de_d | end_bit;
                else         acc_te_d = acc_te_d | end_bit;
            end
            fill_d = base + n_bytes;
            if (in_eop)      in_pkt_d = 1'b0;
            else if (in_sop) in_pkt_d = 1'b1;
        end

        if (accept || xfer) begin
            idle_d = 8'd0;
        end else if ((fill_q != 7'd0) && (idle_q != IDLE_MAX)) begin
            idle_d = idle_q + 8'd1;
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            acc_data_q  <= '0;
            acc_valid_q <= '0;
            acc_ts_q    <= '0;
            acc_te_q    <= '0;
            acc_ds_q    <= '0;
            acc_de_q    <= '0;
            fill_q      <= '0;
            idle_q      <= '0;
            in_pkt_q    <= 1'b0;
            pkt_dlp_q   <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= '0;
            out_ts_q    <= '0;
            out_te_q    <= '0;
            out_ds_q    <= '0;
            out_de_q    <= '0;
            irdy_q      <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            acc_data_q  <= acc_data_d;
            acc_valid_q <= acc_valid_d;
            acc_ts_q    <= acc_ts_d;
            acc_te_q    <= acc_te_d;
            acc_ds_q    <= acc_ds_d;
            acc_de_q    <= acc_de_d;
            fill_q      <= fill_d;
            idle_q      <= idle_d;
            in_pkt_q    <= in_pkt_d;
            pkt_dlp_q   <= pkt_dlp_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_ts_q    <= out_ts_d;
            out_te_q    <= out_te_d;
            out_ds_q    <= out_ds_d;
            out_de_q    <= out_de_d;
            irdy_q      <= irdy_d;
            perr_q      <= perr_d;
        end
    end

    assign lp_data     = out_data_q;
    assign lp_valid    = out_valid_q;
    assign lp_tlpstart = out_ts_q;
    assign lp_tlpend   = out_te_q;
    assign lp_dlpstart = out_ds_q;
    assign lp_dlpend   = out_de_q;
    assign lp_irdy     = irdy_q;
    assign proto_err   = perr_q;

endmodule

// File: tb/tb_lpif_tx_packer.sv
// Directed scenarios plus randomized traffic for lpif_tx_packer, checked every
// cycle against a byte-array reference model of the packing rules.
module tb_lpif_tx_packer;

    localparam int IB = 8;
    localparam int FT = 16;

    logic         pclk = 1'b0;
    logic         reset, in_valid, in_sop, in_eop, in_is_dlp, flush, pl_trdy;
    logic         in_ready, lp_irdy, proto_err;
    logic [63:0]  in_data;
    logic [3:0]   in_bytes;
    logic [511:0] lp_data;
    logic [63:0]  lp_valid, lp_tlpstart, lp_tlpend, lp_dlpstart, lp_dlpend;

    lpif_tx_packer #(.IN_BYTES(IB), .FLUSH_TIMEOUT(FT)) dut (
        .pclk(pclk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_bytes(in_bytes), .in_sop(in_sop), .in_eop(in_eop),
        .in_is_dlp(in_is_dlp), .flush(flush), .lp_data(lp_data), .lp_valid(lp_valid),
        .lp_tlpstart(lp_tlpstart), .lp_tlpend(lp_tlpend), .lp_dlpstart(lp_dlpstart),
        .lp_dlpend(lp_dlpend), .lp_irdy(lp_irdy), .pl_trdy(pl_trdy), .proto_err(proto_err)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_errors = 0;
    int n_words  = 0;
    logic rdy_seen;

    // reference model: pending bytes with per-byte flags, plus the presented word
    int          m_fill, m_idle;
    bit          m_irdy, m_perr, m_inpkt, m_pktdlp;
    logic [7:0]  m_byte [64];
    bit          m_v [64], m_ts [64], m_te [64], m_ds [64], m_de [64];
    logic [511:0] mo_data;
    logic [63:0]  mo_valid, mo_ts, mo_te, mo_ds, mo_de;

    task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
            if (n_errors >= 40) begin
                $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
                $finish;
            end
        end
    endtask

    task automatic model_clear();
        m_fill = 0; m_idle = 0; m_irdy = 0; m_perr = 0; m_inpkt = 0; m_pktdlp = 0;
        for (int k = 0; k < 64; k++) begin
            m_byte[k] = 8'h00; m_v[k] = 0; m_ts[k] = 0; m_te[k] = 0; m_ds[k] = 0; m_de[k] = 0;
        end
        mo_data = '0; mo_valid = '0; mo_ts = '0; mo_te = '0; mo_ds = '0; mo_de = '0;
    endtask

    function automatic bit model_ready();
        return (m_fill <= 64 - IB) || (m_fill > 0 && (!m_irdy || pl_trdy));
    endfunction

    task automatic model_step();
        int n, p, old_fill;
        bit xf, acc, bad, nosop, keep, err, dlp;
        if (reset) begin
            model_clear();
            return;
        end
        n        = int'(in_bytes);
        old_fill = m_fill;
        xf    = (m_fill > 64 - IB || flush || m_idle == FT) && m_fill > 0 && (!m_irdy || pl_trdy);
        acc   = in_valid && model_ready();
        bad   = (n == 0) || (n > IB);
        nosop = !in_sop && !m_inpkt;
        keep  = acc && !bad && !nosop;
        err   = acc && (bad || nosop || (in_sop && m_inpkt) || (n < IB && !in_eop));
        if (m_irdy && pl_trdy) begin
            n_words++;
            $display("word %0d handed off: valid=%h tlpstart=%h tlpend=%h dlpstart=%h dlpend=%h",
                     n_words, mo_valid, mo_ts, mo_te, mo_ds, mo_de);
        end
        if (xf) begin
            for (int k = 0; k < 64; k++) begin
                mo_data[8*k +: 8] = m_v[k] ? m_byte[k] : 8'h00;
                mo_valid[k] = m_v[k]; mo_ts[k] = m_ts[k]; mo_te[k] = m_te[k];
                mo_ds[k] = m_ds[k]; mo_de[k] = m_de[k];
                m_byte[k] = 8'h00; m_v[k] = 0; m_ts[k] = 0; m_te[k] = 0; m_ds[k] = 0; m_de[k] = 0;
            end
            m_irdy = 1;
            m_fill = 0;
        end else if (m_irdy && pl_trdy) begin
            m_irdy = 0;
        end
        p = m_fill;
        if (keep) begin
            dlp = in_sop ? in_is_dlp : m_pktdlp;
            for (int k = 0; k < n; k++) begin
                m_byte[p + k] = in_data[8*k +: 8];
                m_v[p + k] = 1;
            end
            if (in_sop) begin
                if (in_is_dlp) m_ds[p] = 1; else m_ts[p] = 1;
                m_pktdlp = in_is_dlp;
            end
            if (in_eop) begin
                if (dlp) m_de[p + n - 1] = 1; else m_te[p + n - 1] = 1;
            end
            m_fill = p + n;
            if (in_eop) m_inpkt = 0; else if (in_sop) m_inpkt = 1;
        end
        if (acc || xf) m_idle = 0;
        else if (old_fill > 0 && m_idle < FT) m_idle++;
        m_perr = err;
    endtask

    task automatic check_outputs();
        check_val("lp_irdy",     512'(lp_irdy),     512'(m_irdy));
        check_val("proto_err",   512'(proto_err),   512'(m_perr));
        check_val("lp_valid",    512'(lp_valid),    512'(mo_valid));
        check_val("lp_tlpstart", 512'(lp_tlpstart), 512'(mo_ts));
        check_val("lp_tlpend",   512'(lp_tlpend),   512'(mo_te));
        check_val("lp_dlpstart", 512'(lp_dlpstart), 512'(mo_ds));
        check_val("lp_dlpend",   512'(lp_dlpend),   512'(mo_de));
        check_val("lp_data",     lp_data,           mo_data);
    endtask

    // inputs are driven at the falling edge; tick checks in_ready, clocks once,
    // and compares the registered outputs at the next falling edge
    task automatic tick();
        #1;
        rdy_seen = in_ready;
        check_val("in_ready", 512'(in_ready), 512'(model_ready()));
        model_step();
        @(posedge pclk);
        @(negedge pclk);
        check_outputs();
    endtask

    task automatic drive_chunk(input int n, input bit sop, input bit eop, input bit dlp);
        in_valid  = 1'b1;
        in_bytes  = 4'(n);
        in_sop    = sop;
        in_eop    = eop;
        in_is_dlp = dlp;
        in_data   = {$urandom(), $urandom()};
    endtask

    task automatic idle_ticks(input int n);
        in_valid = 1'b0; flush = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int first_hi, lat, hi_cnt, rdy_hi;
        reset = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_is_dlp = 1'b0;
        flush = 1'b0; pl_trdy = 1'b1; in_data = '0; in_bytes = 4'd8;
        model_clear();
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        tick();
        reset = 1'b0;
        check_val("rst_irdy", 512'(lp_irdy), 512'(0));
        check_val("rst_ready", 512'(in_ready), 512'(1));

        // back-to-back full chunks, one 16-chunk TLP
        first_hi = -1;
        for (int i = 0; i < 16; i++) begin
            drive_chunk(8, i == 0, i == 15, 1'b0);
            tick();
            check_val("t1_ready", 512'(rdy_seen), 512'(1));
            if (lp_irdy && first_hi < 0) begin
                first_hi = i;
                check_val("t1_w0_tlpstart", 512'(lp_tlpstart), 512'(64'd1));
                check_val("t1_w0_valid", 512'(lp_valid), 512'({64{1'b1}}));
            end
        end
        check_val("t1_latency", 512'(first_hi + 1 - 7), 512'(2));
        in_valid = 1'b0;
        tick();
        check_val("t1_w1_irdy", 512'(lp_irdy), 512'(1));
        check_val("t1_w1_tlpend", 512'(lp_tlpend), 512'(64'h8000_0000_0000_0000));
        check_val("t1_w1_valid", 512'(lp_valid), 512'({64{1'b1}}));
        idle_ticks(3);

        // lone DLLP flushed by the idle timeout
        drive_chunk(6, 1'b1, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        lat = -1;
        for (int j = 1; j <= 40 && lat < 0; j++) begin
            tick();
            if (lp_irdy) begin
                lat = j + 1;
                check_val("t2_valid", 512'(lp_valid), 512'(64'h3F));
                check_val("t2_dlpstart", 512'(lp_dlpstart), 512'(64'h1));
                check_val("t2_dlpend", 512'(lp_dlpend), 512'(64'h20));
                check_val("t2_data_hi", lp_data >> 48, 512'(0));
            end
        end
        check_val("t2_latency", 512'(lat), 512'(FT + 2));
        idle_ticks(3);

        // 60-byte word followed by a fresh sop chunk that cannot fit
        for (int i = 0; i < 7; i++) begin
            drive_chunk(8, i == 0, 1'b0, 1'b0);
            tick();
        end
        drive_chunk(4, 1'b0, 1'b1, 1'b0);
        tick();
        drive_chunk(8, 1'b1, 1'b0, 1'b0);
        tick();
        check_val("t3_ready", 512'(rdy_seen), 512'(1));
        check_val("t3_w0_valid", 512'(lp_valid), 512'(64'h0FFF_FFFF_FFFF_FFFF));
        drive_chunk(8, 1'b0, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        check_val("t3_w1_tlpstart", 512'(lp_tlpstart), 512'(64'h1));
        check_val("t3_w1_tlpend", 512'(lp_tlpend), 512'(64'h8000));
        idle_ticks(3);

        // PHY backpressure with a full accumulator behind a pending word
        pl_trdy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive_chunk(8, i == 0, 1'b0, 1'b0);
            tick();
        end
        drive_chunk(8, 1'b0, 1'b1, 1'b0);
        rdy_hi = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rdy_seen) rdy_hi++;
        end
        check_val("t4_stall_ready", 512'(rdy_hi), 512'(0));
        check_val("t4_stall_irdy", 512'(lp_irdy), 512'(1));
        pl_trdy = 1'b1;
        tick();
        check_val("t4_release_ready", 512'(rdy_seen), 512'(1));
        check_val("t4_reload_irdy", 512'(lp_irdy), 512'(1));
        check_val("t4_reload_valid", 512'(lp_valid), 512'({64{1'b1}}));
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        check_val("t4_tail_tlpend", 512'(lp_tlpend), 512'(64'h80));
        idle_ticks(3);

        // protocol violations: orphan chunk, zero-length chunk
        drive_chunk(8, 1'b0, 1'b0, 1'b0);
        tick();
        check_val("t5_nosop_err", 512'(proto_err), 512'(1));
        in_valid = 1'b0;
        tick();
        check_val("t5_err_pulse", 512'(proto_err), 512'(0));
        drive_chunk(0, 1'b1, 1'b0, 1'b0);
        tick();
        check_val("t5_len0_err", 512'(proto_err), 512'(1));
        in_valid = 1'b0;
        hi_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (lp_irdy) hi_cnt++;
        end
        check_val("t5_no_word", 512'(hi_cnt), 512'(0));

        // reset in the middle of a packet with a word pending
        pl_trdy = 1'b0;
        for (int i = 0; i < 11; i++) begin
            drive_chunk(8, i == 0, 1'b0, 1'b0);
            tick();
        end
        check_val("t6_pre_irdy", 512'(lp_irdy), 512'(1));
        reset = 1'b1; in_valid = 1'b0;
        tick();
        reset = 1'b0;
        check_val("t6_irdy", 512'(lp_irdy), 512'(0));
        check_val("t6_valid", 512'(lp_valid), 512'(0));
        check_val("t6_data", lp_data, 512'(0));
        check_val("t6_ready", 512'(in_ready), 512'(1));
        pl_trdy = 1'b1;
        drive_chunk(8, 1'b1, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        check_val("t6_tlpstart", 512'(lp_tlpstart), 512'(64'h1));
        check_val("t6_valid_new", 512'(lp_valid), 512'(64'hFF));
        idle_ticks(3);

        // randomized traffic, alternating dense and sparse phases
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(999) == 0);
            pl_trdy   = ($urandom_range(9) < 7);
            flush     = ($urandom_range(99) < 3);
            in_valid  = ((c / 500) % 2 == 0) ? ($urandom_range(9) < 8) : ($urandom_range(9) < 1);
            in_eop    = ($urandom_range(3) == 0);
            in_sop    = m_inpkt ? ($urandom_range(49) == 0) : ($urandom_range(19) != 0);
            in_is_dlp = 1'($urandom_range(1));
            in_bytes  = in_eop ? 4'($urandom_range(8, 1)) : 4'd8;
            if ($urandom_range(49) == 0) in_bytes = 4'($urandom_range(15));
            in_data   = {$urandom(), $urandom()};
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lpif_tx_packer.md
Name: lpif_tx_packer

Overview:
Link-layer-side packer that sits directly upstream of the PHY TX top.
Accepts TLP/DLLP byte chunks from the data link layer and packs them back-to-back into 64-byte LPIF words. Drives lp_data, lp_valid, lp_tlpstart/lp_tlpend and lp_dlpstart/lp_dlpend with per-byte marker bits.
Hands each word to the PHY with an lp_irdy/pl_trdy handshake.

Parameters:
IN_BYTES, 8, bytes per input chunk; power of 2, from 1 to 64.
FLUSH_TIMEOUT, 16, idle cycles with a partial word before it is forced out; valid range 1..255.

Ports:
pclk  in  1  clock.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  input chunk present.
in_ready  out  1  chunk accepted on the edge where in_valid&&in_ready.
in_data  in  8*IN_BYTES  chunk bytes; byte k = in_data[8k+:8]; byte 0 is first on the wire.
in_bytes  in  $clog2(IN_BYTES)+1  count of valid bytes, 1..IN_BYTES, taken from byte 0 upward.
in_sop  in  1  first byte of chunk starts a packet.
in_eop  in  1  last valid byte of chunk ends a packet.
in_is_dlp  in  1  packet is a DLLP (1) or a TLP (0); sampled with in_sop.
flush  in  1  force out the partial word.
lp_data  out  512  packed word.
lp_valid  out  64  per-byte valid.
lp_tlpstart, lp_tlpend, lp_dlpstart, lp_dlpend  out  64 each  per-byte markers.
lp_irdy  out  1  output word valid.
pl_trdy  in  1  PHY accepts the word on an edge where lp_irdy&&pl_trdy.
proto_err  out  1  one-cycle pulse on a protocol violation.

Behaviour:
- Storage is two stages: an accumulator and an output register.
  - Accumulator: 64 data bytes, 64-bit valid mask, 4 marker masks, fill pointer 0..64.
  - Output register: drives all lp_* outputs; its valid bit is lp_irdy.
- Reset: all lp_* outputs are 0, lp_irdy=0, proto_err=0, fill=0, idle count=0, in_pkt=0. Reset mid-operation discards all partial and pending data.
- Terms used below:
  - can_xfer = fill>0 && (!lp_irdy || pl_trdy).
  - seal = fill > 64-IN_BYTES, or flush, or idle count == FLUSH_TIMEOUT.
  - transfer = seal && can_xfer.
- in_ready = (fill <= 64-IN_BYTES) || can_xfer. It is a function of registered state and pl_trdy only; it never depends on in_valid.
- Transfer, on the edge:
  - Output register <= accumulator, lp_irdy <= 1.
  - Unfilled tail bytes carry lp_valid=0 and lp_data=0.
  - Accumulator is cleared and fill <= 0.
- Accept, on an in_valid&&in_ready edge:
  - Base position p = 0 if a transfer happens on the same edge, else p = fill.
  - Bytes 0..in_bytes-1 are written to positions p..p+in_bytes-1, with valid bits set.
  - fill <= p + in_bytes.
  - in_sop sets the start bit at p, in lp_dlpstart if in_is_dlp, else in lp_tlpstart.
  - in_eop sets the end bit at p+in_bytes-1, in the end mask matching the packet type latched at SOP.
  - Chunks are never split across words.
- Output register:
  - Holds stable while lp_irdy && !pl_trdy.
  - Clears lp_irdy on a handshake edge unless a transfer reloads it on the same edge.
- Idle counter:
  - Increments each cycle with fill>0 and no accept; saturates at FLUSH_TIMEOUT.
  - Clears on any accept or transfer.
  - flush with fill==0 has no effect.
- Packet tracking:
  - in_pkt is set by an accepted sop without eop, and cleared by an accepted eop.
  - A single chunk carrying both sop and eop is a complete packet.
- proto_err pulses for one cycle in the cycle after an offending accept:
  - sop while in_pkt: chunk is kept and the new packet starts.
  - non-sop chunk while !in_pkt: chunk is dropped, fill unchanged.
  - in_bytes==0 or in_bytes>IN_BYTES: chunk is dropped, fill unchanged.
  - in_bytes<IN_BYTES without eop: chunk is kept.
- Latency:
  - A chunk that completes a word (fill reaches 64) transfers on the next edge; lp_irdy is high 2 cycles after that chunk's accept cycle.
  - With IN_BYTES=8 and pl_trdy held at 1, throughput is one 64-byte word per 8 cycles with no input bubbles.

Test Plan:
- IN_BYTES=8, pl_trdy=1, 16 back-to-back full chunks, sop on chunk 0 only, eop on chunk 15 only -> two words; lp_irdy first high 2 cycles after the 8th accept; in_ready stays 1 throughout; word0 lp_tlpstart=bit0 only; word1 lp_tlpend=bit63 only; lp_valid all 1s.
- Single DLLP, in_bytes=6, sop=eop=1, in_is_dlp=1, then idle -> lp_irdy rises exactly FLUSH_TIMEOUT+2 cycles after the accept; lp_valid=0x3F, lp_dlpstart bit0, lp_dlpend bit5, lp_data[511:48]=0.
- Fill to 60 bytes (7 full chunks + 4-byte eop chunk), then an 8-byte sop chunk -> first word lp_valid=0x0FFF_FFFF_FFFF_FFFF; new chunk lands at byte 0 of the next word, lp_tlpstart bit0.
- pl_trdy=0 with one word pending and the accumulator full -> in_ready=0; lp_* outputs unchanged for 20 cycles; pl_trdy=1 -> handshake, transfer and accept all occur on the same edge.
- Chunk without sop while idle, and a chunk with in_bytes=0 -> proto_err pulses once each; fill unchanged; no output word is produced.
- reset asserted mid-packet with fill=24 and lp_irdy=1 -> next cycle lp_irdy=0, all lp_* =0, in_ready=1; following sop packet packs from byte 0.
